// File: rtl/azadi_pinmux_pkg.sv
// azadi_pinmux_pkg: owner codes, FSM states and defaults shared by the pad mux controller
package azadi_pinmux_pkg;

    typedef enum logic [1:0] {
        OWN_GPIO   = 2'd0,
        OWN_PERIPH = 2'd1,
        OWN_HIZ    = 2'd2,
        OWN_RSVD   = 2'd3
    } owner_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GUARD  = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    localparam int NUM_PADS_DEF     = 8;
    localparam int GUARD_CYCLES_DEF = 2;

endpackage

// File: rtl/azadi_pinmux_if.sv
// azadi_pinmux_if: configuration request handshake between requester and pad mux controller
interface azadi_pinmux_if #(
    parameter int NUM_PADS = 8
) ();
    localparam int SW = NUM_PADS > 1 ? $clog2(NUM_PADS) : 1;

    logic          cfg_valid_i;
    logic          cfg_ready_o;
    logic [SW-1:0] cfg_slot_i;
    logic [1:0]    cfg_sel_i;
    logic          cfg_err_o;

    modport master (
        output cfg_valid_i, cfg_slot_i, cfg_sel_i,
        input  cfg_ready_o, cfg_err_o
    );

    modport slave (
        input  cfg_valid_i, cfg_slot_i, cfg_sel_i,
        output cfg_ready_o, cfg_err_o
    );
endinterface

// File: rtl/azadi_pinmux_slot.sv
// azadi_pinmux_slot: one pad's output mux; high-Z when forced or when no driving owner
module azadi_pinmux_slot
    import azadi_pinmux_pkg::*;
(
    input  logic [1:0] owner,
    input  logic       force_hz,
    input  logic       gpio_out,
    input  logic       gpio_oe,
    input  logic       per_out,
    input  logic       per_oe,
    output logic       pad_out,
    output logic       pad_oeb
);
    logic gpio, hz;

    assign gpio    = owner == OWN_GPIO;
    assign hz      = force_hz || !(gpio || owner == OWN_PERIPH);
    assign pad_out = !hz && (gpio ? gpio_out : per_out);
    assign pad_oeb = hz || !(gpio ? gpio_oe : per_oe);
endmodule

// File: rtl/azadi_pinmux_ctrl.sv
// azadi_pinmux_ctrl: pad ownership switcher with high-Z guard interval and sticky lock
module azadi_pinmux_ctrl
    import azadi_pinmux_pkg::*;
#(
    parameter int NUM_PADS     = NUM_PADS_DEF,
    parameter int GUARD_CYCLES = GUARD_CYCLES_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    azadi_pinmux_if.slave         cfg,
    input  logic                  lock_i,
    input  logic [NUM_PADS-1:0]   per_out_i,
    input  logic [NUM_PADS-1:0]   per_oe_i,
    input  logic [NUM_PADS-1:0]   gpio_out_i,
    input  logic [NUM_PADS-1:0]   gpio_oe_i,
    output logic [NUM_PADS-1:0]   pad_out_o,
    output logic [NUM_PADS-1:0]   pad_oeb_o,
    output logic [2*NUM_PADS-1:0] owner_o,
    output logic                  busy_o
);
    localparam int SW = NUM_PADS > 1 ? $clog2(NUM_PADS) : 1;

    state_e                     state_q, state_d;
    logic [3:0]                 cnt_q, cnt_d;
    logic                       lock_q, err_q;
    logic                       accept, in_range, reject, start, commit;
    logic [NUM_PADS-1:0]        hz_q;
    logic [NUM_PADS-1:0][1:0]   owner_q;
    logic [SW-1:0]              slot_q;
    logic [1:0]                 sel_q;

    assign accept   = cfg.cfg_valid_i && state_q == ST_IDLE;
    assign in_range = {1'b0, cfg.cfg_slot_i} < (SW+1)'(NUM_PADS);
    assign reject   = lock_q || cfg.cfg_sel_i == OWN_RSVD || !in_range;
    // Re-selecting the current owner is accepted silently with no guard interval
    assign start    = accept && !reject && cfg.cfg_sel_i != owner_q[cfg.cfg_slot_i];
    assign commit   = state_q == ST_COMMIT;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                state_d = start ? ST_GUARD : ST_IDLE;
                cnt_d   = start ? 4'(GUARD_CYCLES) : cnt_q;
            end
            ST_GUARD: begin
                state_d = cnt_q == 4'd1 ? ST_COMMIT : ST_GUARD;
                cnt_d   = cnt_q - 4'd1;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lock_q  <= 1'b0;
            err_q   <= 1'b0;
            hz_q    <= '0;
            owner_q <= {NUM_PADS{OWN_HIZ}};
            slot_q  <= '0;
            sel_q   <= OWN_HIZ;
        end else begin
            lock_q <= lock_q || lock_i;
            err_q  <= accept && reject;
            if (start) begin
                slot_q               <= cfg.cfg_slot_i;
                sel_q                <= cfg.cfg_sel_i;
                hz_q[cfg.cfg_slot_i] <= 1'b1;
            end
            if (commit) begin
                owner_q[slot_q] <= sel_q;
                hz_q            <= '0;
            end
        end
    end

    assign cfg.cfg_ready_o = state_q == ST_IDLE;
    assign cfg.cfg_err_o   = err_q;
    assign busy_o          = state_q != ST_IDLE;
    assign owner_o         = owner_q;

    for (genvar i = 0; i < NUM_PADS; i++) begin : g_slot
        azadi_pinmux_slot u_slot (
            .owner    (owner_q[i]),
            .force_hz (hz_q[i]),
            .gpio_out (gpio_out_i[i]),
            .gpio_oe  (gpio_oe_i[i]),
            .per_out  (per_out_i[i]),
            .per_oe   (per_oe_i[i]),
            .pad_out  (pad_out_o[i]),
            .pad_oeb  (pad_oeb_o[i])
        );
    end
endmodule

// File: tb/tb_azadi_pinmux_ctrl.sv
// tb_azadi_pinmux_ctrl: scoreboard bench; per-cycle expected pad/status snapshots queued then compared
module tb_azadi_pinmux_ctrl;
    import azadi_pinmux_pkg::*;

    localparam int N = 8;
    localparam int G = 2;

    typedef struct packed {
        logic [N-1:0]   oeb;
        logic [N-1:0]   out;
        logic [2*N-1:0] owner;
        logic           busy;
        logic           err;
        logic           ready;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_ni = 1'b0;
    logic           lock_i = 1'b0;
    logic [N-1:0]   per_out_i = 8'h5A;
    logic [N-1:0]   per_oe_i = 8'hCF;
    logic [N-1:0]   gpio_out_i = 8'h33;
    logic [N-1:0]   gpio_oe_i = 8'hA7;
    logic [N-1:0]   pad_out_o, pad_oeb_o;
    logic [2*N-1:0] owner_o;
    logic           busy_o;
    exp_t           obs;
    exp_t           sb[$];
    logic [1:0]     m_owner[N];
    logic [N-1:0]   m_force = '0;
    int             n_chk = 0;
    int             n_fail = 0;

    azadi_pinmux_if #(.NUM_PADS(N)) cfg ();

    azadi_pinmux_ctrl #(.NUM_PADS(N), .GUARD_CYCLES(G)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_ni),
        .cfg        (cfg),
        .lock_i     (lock_i),
        .per_out_i  (per_out_i),
        .per_oe_i   (per_oe_i),
        .gpio_out_i (gpio_out_i),
        .gpio_oe_i  (gpio_oe_i),
        .pad_out_o  (pad_out_o),
        .pad_oeb_o  (pad_oeb_o),
        .owner_o    (owner_o),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    assign obs = {pad_oeb_o, pad_out_o, owner_o, busy_o, cfg.cfg_err_o, cfg.cfg_ready_o};

    // Expected outputs from the bench's own owner/force model
    function automatic exp_t mk(logic b, logic er, logic r);
        exp_t x;
        x.busy  = b;
        x.err   = er;
        x.ready = r;
        for (int i = 0; i < N; i++) begin
            logic hz;
            hz = m_force[i] || (m_owner[i] != OWN_GPIO && m_owner[i] != OWN_PERIPH);
            x.owner[2*i+:2] = m_owner[i];
            x.out[i] = hz ? 1'b0 : (m_owner[i] == OWN_GPIO ? gpio_out_i[i] : per_out_i[i]);
            x.oeb[i] = hz ? 1'b1 : (m_owner[i] == OWN_GPIO ? ~gpio_oe_i[i] : ~per_oe_i[i]);
        end
        return x;
    endfunction

    task automatic test_reset();
        exp_t e;
        sb.push_back(mk(0, 0, 1));
        sb.push_back(mk(0, 0, 1));
        repeat (2) @(negedge clk);
        #4;
        e = sb.pop_front(); n_chk++;
        if (obs !== e) begin n_fail++; $display("FAIL reset_held got %h want %h", obs, e); end
        @(negedge clk); rst_ni = 1'b1;
        #4;
        e = sb.pop_front(); n_chk++;
        if (obs !== e) begin n_fail++; $display("FAIL reset_release got %h want %h", obs, e); end
    endtask

    task automatic test_switch(input logic [2:0] s, input logic [1:0] v);
        exp_t e;
        sb.push_back(mk(0, 0, 1));
        m_force[s] = 1'b1;
        repeat (G + 1) sb.push_back(mk(1, 0, 0));
        m_force[s] = 1'b0;
        m_owner[s] = v;
        sb.push_back(mk(0, 0, 1));
        @(negedge clk); cfg.cfg_valid_i = 1'b1; cfg.cfg_slot_i = s; cfg.cfg_sel_i = v;
        for (int k = 0; k < G + 3; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 1) cfg.cfg_valid_i = 1'b0;
            #4;
            e = sb.pop_front(); n_chk++;
            if (obs !== e) begin n_fail++; $display("FAIL switch slot%0d->%0d T+%0d got %h want %h", s, v, k, obs, e); end
        end
    endtask

    task automatic test_noop();
        exp_t e;
        repeat (3) sb.push_back(mk(0, 0, 1));
        @(negedge clk); cfg.cfg_valid_i = 1'b1; cfg.cfg_slot_i = 3'd5; cfg.cfg_sel_i = OWN_GPIO;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 1) cfg.cfg_valid_i = 1'b0;
            #4;
            e = sb.pop_front(); n_chk++;
            if (obs !== e) begin n_fail++; $display("FAIL noop T+%0d got %h want %h", k, obs, e); end
        end
    endtask

    task automatic test_reject_rsvd();
        exp_t e;
        sb.push_back(mk(0, 0, 1));
        sb.push_back(mk(0, 1, 1));
        sb.push_back(mk(0, 0, 1));
        @(negedge clk); cfg.cfg_valid_i = 1'b1; cfg.cfg_slot_i = 3'd2; cfg.cfg_sel_i = OWN_RSVD;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 1) cfg.cfg_valid_i = 1'b0;
            #4;
            e = sb.pop_front(); n_chk++;
            if (obs !== e) begin n_fail++; $display("FAIL reject_rsvd T+%0d got %h want %h", k, obs, e); end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        sb.push_back(mk(0, 0, 1));
        m_force[1] = 1'b1;
        repeat (G + 1) sb.push_back(mk(1, 0, 0));
        m_force[1] = 1'b0;
        m_owner[1] = OWN_GPIO;
        sb.push_back(mk(0, 0, 1));
        m_force[6] = 1'b1;
        repeat (G + 1) sb.push_back(mk(1, 0, 0));
        m_force[6] = 1'b0;
        m_owner[6] = OWN_PERIPH;
        sb.push_back(mk(0, 0, 1));
        @(negedge clk); cfg.cfg_valid_i = 1'b1; cfg.cfg_slot_i = 3'd1; cfg.cfg_sel_i = OWN_GPIO;
        for (int k = 0; k < 2*G + 5; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 1) begin cfg.cfg_slot_i = 3'd6; cfg.cfg_sel_i = OWN_PERIPH; end
            if (k == G + 3) cfg.cfg_valid_i = 1'b0;
            #4;
            e = sb.pop_front(); n_chk++;
            if (obs !== e) begin n_fail++; $display("FAIL back_to_back T+%0d got %h want %h", k, obs, e); end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        sb.push_back(mk(0, 0, 1));
        m_force[0] = 1'b1;
        sb.push_back(mk(1, 0, 0));
        m_force = '0;
        for (int i = 0; i < N; i++) m_owner[i] = OWN_HIZ;
        repeat (5) sb.push_back(mk(0, 0, 1));
        @(negedge clk); cfg.cfg_valid_i = 1'b1; cfg.cfg_slot_i = 3'd0; cfg.cfg_sel_i = OWN_GPIO;
        for (int k = 0; k < 2; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 1) cfg.cfg_valid_i = 1'b0;
            #4;
            e = sb.pop_front(); n_chk++;
            if (obs !== e) begin n_fail++; $display("FAIL reset_mid T+%0d got %h want %h", k, obs, e); end
        end
        @(negedge clk); rst_ni = 1'b0;
        #1;
        e = sb.pop_front(); n_chk++;
        if (obs !== e) begin n_fail++; $display("FAIL reset_mid_async got %h want %h", obs, e); end
        @(negedge clk); rst_ni = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            #4;
            e = sb.pop_front(); n_chk++;
            if (obs !== e) begin n_fail++; $display("FAIL reset_mid_after R+%0d got %h want %h", k, obs, e); end
        end
    endtask

    task automatic test_lock();
        exp_t e;
        sb.push_back(mk(0, 0, 1));
        m_force[7] = 1'b1;
        repeat (G + 1) sb.push_back(mk(1, 0, 0));
        m_force[7] = 1'b0;
        m_owner[7] = OWN_GPIO;
        sb.push_back(mk(0, 0, 1));
        sb.push_back(mk(0, 0, 1));
        sb.push_back(mk(0, 1, 1));
        sb.push_back(mk(0, 0, 1));
        @(negedge clk); cfg.cfg_valid_i = 1'b1; cfg.cfg_slot_i = 3'd7; cfg.cfg_sel_i = OWN_GPIO;
        for (int k = 0; k < G + 6; k++) begin
            if (k > 0) @(negedge clk);
            if (k == 1) begin cfg.cfg_valid_i = 1'b0; lock_i = 1'b1; end
            if (k == 2) lock_i = 1'b0;
            if (k == G + 3) begin cfg.cfg_valid_i = 1'b1; cfg.cfg_slot_i = 3'd4; cfg.cfg_sel_i = OWN_GPIO; end
            if (k == G + 4) cfg.cfg_valid_i = 1'b0;
            #4;
            e = sb.pop_front(); n_chk++;
            if (obs !== e) begin n_fail++; $display("FAIL lock T+%0d got %h want %h", k, obs, e); end
        end
    endtask

    initial begin
        cfg.cfg_valid_i = 1'b0;
        cfg.cfg_slot_i  = '0;
        cfg.cfg_sel_i   = OWN_HIZ;
        for (int i = 0; i < N; i++) m_owner[i] = OWN_HIZ;
        test_reset();
        test_switch(3'd3, OWN_PERIPH);
        test_switch(3'd5, OWN_GPIO);
        test_noop();
        test_reject_rsvd();
        test_switch(3'd2, OWN_PERIPH);
        test_back_to_back();
        test_reset_mid();
        test_lock();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/azadi_pinmux_ctrl.md
AZADI_PINMUX_CTRL -- requirements
Module: azadi_pinmux_ctrl

Interface
REQ-001 The module SHALL provide parameter NUM_PADS, default 8: the number of shared pad slots.
REQ-002 The module SHALL provide parameter GUARD_CYCLES, default 2, legal range 1..15: the number of high-Z guard cycles inserted on an owner change.
REQ-003 clk_i  in  1  single system clock.
REQ-004 rst_ni  in  1  asynchronous, active-low reset.
REQ-005 cfg_valid_i  in  1  configuration request valid.
REQ-006 cfg_ready_o  out  1  configuration request accepted when high together with cfg_valid_i.
REQ-007 cfg_slot_i  in  $clog2(NUM_PADS)  target slot.
REQ-008 cfg_sel_i  in  2  requested owner: 0=GPIO, 1=PERIPH, 2=HIZ, 3=reserved.
REQ-009 cfg_err_o  out  1  one-cycle pulse flagging a rejected request.
REQ-010 lock_i  in  1  lock request; once set, the lock is sticky.
REQ-011 per_out_i / per_oe_i  in  NUM_PADS each  peripheral data and active-high output enable.
REQ-012 gpio_out_i / gpio_oe_i  in  NUM_PADS each  GPIO data and active-high output enable.
REQ-013 pad_out_o  out  NUM_PADS  pad data.
REQ-014 pad_oeb_o  out  NUM_PADS  pad output enable, active low.
REQ-015 owner_o  out  2*NUM_PADS  current owner code of each slot.
REQ-016 busy_o  out  1  a switch sequence is in progress.

Function
REQ-017 The controller SHALL use an FSM with states IDLE, GUARD and COMMIT, and SHALL process one switch at a time across all slots.
REQ-018 cfg_ready_o SHALL be 1 only in IDLE; busy_o SHALL be 1 in GUARD and COMMIT.
REQ-019 A request accepted in cycle T SHALL be rejected when the lock is set, when cfg_sel_i=3, or when cfg_slot_i>=NUM_PADS; a rejection SHALL raise cfg_err_o in cycle T+1 for exactly one cycle and SHALL leave owners and state unchanged.
REQ-020 An accepted request whose cfg_sel_i equals the slot's current owner SHALL be a no-op: no error, the FSM stays in IDLE, and no guard interval is inserted.
REQ-021 Any other accepted request SHALL latch the slot and target, force that slot high-Z from T+1, and enter GUARD.
REQ-022 GUARD SHALL last exactly GUARD_CYCLES cycles (T+1..T+GUARD_CYCLES), counted by a 4-bit down-counter.
REQ-023 COMMIT SHALL occupy cycle T+GUARD_CYCLES+1, with the slot still high-Z, and SHALL update the owner register at the end of that cycle before the FSM returns to IDLE.
REQ-024 The new owner SHALL drive the pad from cycle T+GUARD_CYCLES+2; cfg_ready_o SHALL be 1 again in that cycle.
REQ-025 Pad outputs SHALL be combinational from the owner registers and the force mask as follows:
  - owner=GPIO: pad_out=gpio_out, pad_oeb=~gpio_oe.
  - owner=PERIPH: pad_out=per_out, pad_oeb=~per_oe.
  - owner=HIZ, or slot forced: pad_out=0, pad_oeb=1.
REQ-026 Slots other than the one being switched SHALL be unaffected throughout a sequence.
REQ-027 lock_i SHALL be sampled every cycle; once it is seen high, the lock SHALL stay set until reset.
REQ-028 If the lock becomes set during GUARD, the in-flight switch SHALL still complete.
REQ-029 cfg_valid_i asserted while not in IDLE SHALL be ignored without error; the requester SHALL hold it until cfg_ready_o is high.

Reset
REQ-030 On rst_ni low, asynchronously:
  - FSM to IDLE, counter to 0, lock cleared, force mask cleared.
  - All owners to HIZ (owner_o = all slots code 2).
  - pad_oeb_o all 1, pad_out_o all 0, cfg_err_o 0, busy_o 0.
REQ-031 cfg_ready_o SHALL be 1 in the first cycle after reset release.
REQ-032 A reset asserted mid-sequence SHALL abandon the switch; the target owner SHALL NOT be committed.

Structure
REQ-033 The owner codes (GPIO/PERIPH/HIZ/RSVD), the FSM state enum and the GUARD_CYCLES default SHALL live in a shared package, azadi_pinmux_pkg.
REQ-034 The per-slot output mux SHALL be one sub-module, azadi_pinmux_slot, instantiated NUM_PADS times; the FSM and registers SHALL be in the top module.

Verification
REQ-035 Reset release: pad_oeb_o=8'hFF, pad_out_o=0, owner_o all 2'b10, cfg_ready_o=1.
REQ-036 Slot 3 set to PERIPH at T with per_oe_i[3]=1 and per_out_i[3]=1: pad_oeb_o[3]=1 during T+1..T+3, pad_out_o[3]=1 and pad_oeb_o[3]=0 at T+4, busy_o high during T+1..T+3.
REQ-037 Slot 5 set to GPIO while it already is GPIO: no busy_o, no cfg_err_o, cfg_ready_o held 1.
REQ-038 cfg_sel_i=3, and separately any write after a lock_i pulse: cfg_err_o is a single pulse at T+1 and owner_o is unchanged.
REQ-039 rst_ni asserted at T+2 of a slot 0 to GPIO switch: owner_o[1:0]=HIZ and pad_oeb_o[0]=1 immediately; after release, no commit occurs.
REQ-040 Back-to-back requests with cfg_valid_i held high: the second is accepted only at T+4, and slot 1 toggling to GPIO does not disturb slot 2 owned by PERIPH.
